// File: rtl/pipe_msg_pkg.sv
// Shared M2P/P2M message layout: widths,
// header field positions and header view.
package pipe_msg_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int MSG_WIDTH   = 128;
  localparam int BEATS       = MSG_WIDTH / DATA_WIDTH;

  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 16;
  localparam int HDR_ID_LSB  = 16;
  localparam int HDR_ID_W    = 16;

  typedef struct packed {
    logic [HDR_ID_W-1:0]  id;
    logic [HDR_LEN_W-1:0] len;
  } pipe_hdr_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } pipe_st_e;

  function automatic pipe_hdr_t hdr_of(
    input logic [HDR_ID_W+HDR_LEN_W-1:0] w
  );
    return pipe_hdr_t'(w);
  endfunction

endpackage

// File: rtl/pipe_msg_serializer.sv
// Serialises one wide pipe message into
// low-word-first beats with a last flag.
module pipe_msg_serializer
  import pipe_msg_pkg::*;
#(
  parameter int DATA_WIDTH = pipe_msg_pkg::DATA_WIDTH,
  parameter int MSG_WIDTH  = pipe_msg_pkg::MSG_WIDTH,
  parameter int ERRW       = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  pipe_enq__ENA,
  input  logic [MSG_WIDTH-1:0]  pipe_enq_v,
  output logic                  pipe_enq__RDY,
  output logic                  out_enq__ENA,
  output logic [DATA_WIDTH-1:0] out_enq_v,
  output logic                  out_enq_last,
  input  logic                  out_enq__RDY,
  output logic                  busy,
  output logic [15:0]           msg_count,
  output logic [ERRW-1:0]       err_count
);

  localparam int NB   = MSG_WIDTH / DATA_WIDTH;
  localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam int LENW = $clog2(NB + 1);

  localparam logic [LENW-1:0] NB_L =
    LENW'(NB);
  localparam logic [HDR_LEN_W-1:0] NB_H =
    HDR_LEN_W'(NB);

  pipe_st_e              state_q;
  logic [MSG_WIDTH-1:0]  msg_q;
  logic [IDXW-1:0]       idx_q;
  logic [LENW-1:0]       len_q;
  logic [15:0]           msg_cnt_q;
  logic [ERRW-1:0]       err_q;

  logic                  send;
  logic                  last;
  logic                  xfer;
  logic                  done;
  logic                  acc;
  logic [HDR_LEN_W-1:0]  l_in;
  logic                  len_zero;
  logic                  len_big;
  logic [DATA_WIDTH-1:0] beat;

  assign send = (state_q == ST_SEND);

  assign last = send &
    (idx_q == IDXW'(len_q - LENW'(1)));

  assign xfer = send & out_enq__RDY;
  assign done = xfer & last;

  // Reload allowed on the last-beat
  // transfer cycle for zero-bubble.
  assign pipe_enq__RDY = ~send | done;

  assign acc = pipe_enq__ENA & pipe_enq__RDY;

  assign l_in =
    pipe_enq_v[HDR_LEN_LSB +: HDR_LEN_W];

  assign len_zero = (l_in == '0);
  assign len_big  = (l_in > NB_H);

  // Beat select mux on the beat index.
  always_comb begin
    beat = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx_q == IDXW'(i)) begin
        beat = msg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_enq__ENA = send;
  assign out_enq_v    = send ? beat : '0;
  assign out_enq_last = last;
  assign busy         = send;
  assign msg_count    = msg_cnt_q;
  assign err_count    = err_q;

  // Message FSM: load, step beats,
  // reload or retire on last beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
    end else if (acc) begin
      msg_q <= pipe_enq_v;
      idx_q <= '0;
      if (len_zero) begin
        state_q <= ST_IDLE;
      end else if (len_big) begin
        len_q   <= NB_L;
        state_q <= ST_SEND;
      end else begin
        len_q   <= l_in[LENW-1:0];
        state_q <= ST_SEND;
      end
    end else if (done) begin
      state_q <= ST_IDLE;
    end else if (xfer) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Completed messages, wrapping.
  always_ff @(posedge CLK) begin
    if (RST) begin
      msg_cnt_q <= '0;
    end else if (done) begin
      msg_cnt_q <= msg_cnt_q + 16'd1;
    end
  end

  // Malformed headers, saturating.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= '0;
    end else if (acc & (len_zero | len_big)
                 & ~(&err_q)) begin
      err_q <= err_q + ERRW'(1);
    end
  end

  a_enq_rdy: assert property (
    @(posedge CLK) disable iff (RST)
    pipe_enq__ENA |-> pipe_enq__RDY
  );

  a_hold: assert property (
    @(posedge CLK) disable iff (RST)
    (out_enq__ENA & !out_enq__RDY) |=>
      ($stable(out_enq_v) &&
       $stable(out_enq_last) &&
       out_enq__ENA)
  );

endmodule

// File: tb/tb_pipe_msg_serializer.sv
// Directed bench for pipe_msg_serializer.
// ERRW is narrowed so saturation is reachable.
module tb_pipe_msg_serializer;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         pe_ena = 1'b0;
  logic [127:0] pe_v = '0;
  logic         pe_rdy;
  logic         oe_ena;
  logic [31:0]  oe_v;
  logic         oe_last;
  logic         oe_rdy = 1'b1;
  logic         busy;
  logic [15:0]  msg_cnt;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_msg_serializer #(
    .DATA_WIDTH(32),
    .MSG_WIDTH(128),
    .ERRW(8)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .pipe_enq__ENA(pe_ena),
    .pipe_enq_v(pe_v),
    .pipe_enq__RDY(pe_rdy),
    .out_enq__ENA(oe_ena),
    .out_enq_v(oe_v),
    .out_enq_last(oe_last),
    .out_enq__RDY(oe_rdy),
    .busy(busy),
    .msg_count(msg_cnt),
    .err_count(err_cnt)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    pe_ena = 1'b0;
    oe_rdy = 1'b1;
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (oe_ena !== 1'b0 || busy !== 1'b0 ||
        pe_rdy !== 1'b1 || msg_cnt !== 16'd0 ||
        err_cnt !== 8'd0 || oe_v !== 32'd0 ||
        oe_last !== 1'b0) begin
      errors++;
      $display("FAIL reset got ena=%0b busy=%0b rdy=%0b msg=%h err=%h v=%h last=%0b want 0 0 1 0000 00 00000000 0",
               oe_ena, busy, pe_rdy, msg_cnt, err_cnt, oe_v, oe_last);
    end
  endtask

  task automatic test_basic;
    pe_v = {64'd0, 32'hDEADBEEF, 16'd0, 16'd2};
    pe_ena = 1'b1;
    oe_rdy = 1'b1;
    #1;
    checks++;
    if (pe_rdy !== 1'b1) begin
      errors++;
      $display("FAIL t1_idle_rdy got %0b want 1", pe_rdy);
    end
    tick();
    pe_ena = 1'b0;
    #1;
    checks++;
    if (oe_ena !== 1'b1 || oe_v !== 32'h00000002 ||
        oe_last !== 1'b0 || pe_rdy !== 1'b0) begin
      errors++;
      $display("FAIL t1_beat0 got ena=%0b v=%h last=%0b rdy=%0b want 1 00000002 0 0",
               oe_ena, oe_v, oe_last, pe_rdy);
    end
    tick();
    checks++;
    if (oe_ena !== 1'b1 || oe_v !== 32'hDEADBEEF ||
        oe_last !== 1'b1 || pe_rdy !== 1'b1) begin
      errors++;
      $display("FAIL t1_beat1 got ena=%0b v=%h last=%0b rdy=%0b want 1 deadbeef 1 1",
               oe_ena, oe_v, oe_last, pe_rdy);
    end
    tick();
    checks++;
    if (oe_ena !== 1'b0 || busy !== 1'b0 ||
        msg_cnt !== 16'd1 || oe_v !== 32'd0) begin
      errors++;
      $display("FAIL t1_done got ena=%0b busy=%0b msg=%0d v=%h want 0 0 1 00000000",
               oe_ena, busy, msg_cnt, oe_v);
    end
  endtask

  task automatic test_stall;
    logic [31:0] exp [4];
    exp[0] = 32'h00020004;
    exp[1] = 32'h22221111;
    exp[2] = 32'h33332222;
    exp[3] = 32'h44443333;
    pe_v = {16'h4444, 32'h33333333, 32'h22222222,
            16'h1111, 16'd2, 16'd4};
    pe_ena = 1'b1;
    tick();
    pe_ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      oe_rdy = 1'b0;
      #1;
      checks++;
      if (oe_ena !== 1'b1 || oe_v !== exp[k] ||
          oe_last !== (k == 3) || pe_rdy !== 1'b0) begin
        errors++;
        $display("FAIL t2_beat%0d got ena=%0b v=%h last=%0b rdy=%0b want 1 %h %0b 0",
                 k, oe_ena, oe_v, oe_last, pe_rdy, exp[k], (k == 3));
      end
      tick();
      oe_rdy = 1'b1;
      #1;
      checks++;
      if (oe_ena !== 1'b1 || oe_v !== exp[k] ||
          oe_last !== (k == 3) || pe_rdy !== (k == 3)) begin
        errors++;
        $display("FAIL t2_hold%0d got ena=%0b v=%h last=%0b rdy=%0b want 1 %h %0b %0b",
                 k, oe_ena, oe_v, oe_last, pe_rdy, exp[k], (k == 3), (k == 3));
      end
      tick();
    end
    checks++;
    if (oe_ena !== 1'b0 || msg_cnt !== 16'd2) begin
      errors++;
      $display("FAIL t2_done got ena=%0b msg=%0d want 0 2",
               oe_ena, msg_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp [4];
    exp[0] = 32'h00AA0002;
    exp[1] = 32'h11111111;
    exp[2] = 32'h00BB0002;
    exp[3] = 32'h22222222;
    oe_rdy = 1'b1;
    pe_v = {64'd0, 32'h11111111, 32'h00AA0002};
    pe_ena = 1'b1;
    tick();
    pe_ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        pe_v = {64'd0, 32'h22222222, 32'h00BB0002};
        pe_ena = 1'b1;
      end
      #1;
      checks++;
      if (oe_ena !== 1'b1 || oe_v !== exp[k] ||
          oe_last !== (k[0] == 1'b1)) begin
        errors++;
        $display("FAIL t3_beat%0d got ena=%0b v=%h last=%0b want 1 %h %0b",
                 k, oe_ena, oe_v, oe_last, exp[k], k[0]);
      end
      if (k == 1) begin
        checks++;
        if (pe_rdy !== 1'b1) begin
          errors++;
          $display("FAIL t3_reload_rdy got %0b want 1", pe_rdy);
        end
      end
      tick();
      pe_ena = 1'b0;
    end
    checks++;
    if (oe_ena !== 1'b0 || msg_cnt !== 16'd4) begin
      errors++;
      $display("FAIL t3_done got ena=%0b msg=%0d want 0 4",
               oe_ena, msg_cnt);
    end
  endtask

  task automatic test_bad_len;
    logic [31:0] exp [4];
    exp[0] = 32'h00000007;
    exp[1] = 32'h77770001;
    exp[2] = 32'h77770002;
    exp[3] = 32'h77770003;
    oe_rdy = 1'b1;
    pe_v = {96'h5, 32'h00AB0000};
    pe_ena = 1'b1;
    tick();
    pe_ena = 1'b0;
    #1;
    checks++;
    if (oe_ena !== 1'b0 || busy !== 1'b0 ||
        pe_rdy !== 1'b1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL t4_len0 got ena=%0b busy=%0b rdy=%0b err=%0d want 0 0 1 1",
               oe_ena, busy, pe_rdy, err_cnt);
    end
    pe_v = {exp[3], exp[2], exp[1], exp[0]};
    pe_ena = 1'b1;
    tick();
    pe_ena = 1'b0;
    #1;
    checks++;
    if (err_cnt !== 8'd2) begin
      errors++;
      $display("FAIL t4_err got %0d want 2", err_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oe_ena !== 1'b1 || oe_v !== exp[k] ||
          oe_last !== (k == 3)) begin
        errors++;
        $display("FAIL t4_beat%0d got ena=%0b v=%h last=%0b want 1 %h %0b",
                 k, oe_ena, oe_v, oe_last, exp[k], (k == 3));
      end
      tick();
    end
    checks++;
    if (oe_ena !== 1'b0 || msg_cnt !== 16'd5) begin
      errors++;
      $display("FAIL t4_done got ena=%0b msg=%0d want 0 5",
               oe_ena, msg_cnt);
    end
  endtask

  task automatic test_mid_reset;
    oe_rdy = 1'b1;
    pe_v = {32'h4, 32'h3, 32'h2, 32'h00000004};
    pe_ena = 1'b1;
    tick();
    pe_ena = 1'b0;
    tick();
    checks++;
    if (oe_ena !== 1'b1 || oe_v !== 32'h2) begin
      errors++;
      $display("FAIL t5_pre got ena=%0b v=%h want 1 00000002",
               oe_ena, oe_v);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    checks++;
    if (oe_ena !== 1'b0 || busy !== 1'b0 ||
        pe_rdy !== 1'b1 || msg_cnt !== 16'd0 ||
        err_cnt !== 8'd0 || oe_last !== 1'b0) begin
      errors++;
      $display("FAIL t5_abort got ena=%0b busy=%0b rdy=%0b msg=%0d err=%0d last=%0b want 0 0 1 0 0 0",
               oe_ena, busy, pe_rdy, msg_cnt, err_cnt, oe_last);
    end
    pe_v = {64'd0, 32'hCAFEF00D, 32'h00050002};
    pe_ena = 1'b1;
    tick();
    pe_ena = 1'b0;
    #1;
    checks++;
    if (oe_ena !== 1'b1 || oe_v !== 32'h00050002 ||
        oe_last !== 1'b0) begin
      errors++;
      $display("FAIL t5_beat0 got ena=%0b v=%h last=%0b want 1 00050002 0",
               oe_ena, oe_v, oe_last);
    end
    tick();
    checks++;
    if (oe_ena !== 1'b1 || oe_v !== 32'hCAFEF00D ||
        oe_last !== 1'b1) begin
      errors++;
      $display("FAIL t5_beat1 got ena=%0b v=%h last=%0b want 1 cafef00d 1",
               oe_ena, oe_v, oe_last);
    end
    tick();
    checks++;
    if (oe_ena !== 1'b0 || msg_cnt !== 16'd1) begin
      errors++;
      $display("FAIL t5_done got ena=%0b msg=%0d want 0 1",
               oe_ena, msg_cnt);
    end
  endtask

  task automatic test_counters;
    int acc;
    int cyc;
    do_reset();
    pe_v = 128'h0;
    pe_ena = 1'b1;
    repeat (300) tick();
    pe_ena = 1'b0;
    #1;
    checks++;
    if (err_cnt !== 8'hFF || msg_cnt !== 16'd0 ||
        oe_ena !== 1'b0) begin
      errors++;
      $display("FAIL t6_err_sat got err=%h msg=%0d ena=%0b want ff 0 0",
               err_cnt, msg_cnt, oe_ena);
    end
    pe_v = 128'h1;
    pe_ena = 1'b1;
    acc = 0;
    cyc = 0;
    while (acc < 65536 && cyc < 70000) begin
      #1;
      if (pe_rdy === 1'b1) acc++;
      cyc++;
      tick();
    end
    pe_ena = 1'b0;
    #1;
    checks++;
    if (acc !== 65536) begin
      errors++;
      $display("FAIL t6_stream got %0d accepts want 65536", acc);
    end
    checks++;
    if (msg_cnt !== 16'hFFFF || oe_v !== 32'h1 ||
        oe_last !== 1'b1) begin
      errors++;
      $display("FAIL t6_pre_wrap got msg=%h v=%h last=%0b want ffff 00000001 1",
               msg_cnt, oe_v, oe_last);
    end
    tick();
    checks++;
    if (msg_cnt !== 16'h0000 || oe_ena !== 1'b0 ||
        err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL t6_wrap got msg=%h ena=%0b err=%h want 0000 0 ff",
               msg_cnt, oe_ena, err_cnt);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_bad_len();
    test_mid_reset();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
